// File: rtl/rv32m_iterative_unit.sv
// RV32M execute unit: one shared 32-step shift-add multiplier / restoring divider.
// A start/busy/done handshake lets the pipeline stall execute until the result is ready.
module rv32m_iterative_unit #(
    parameter int NUM_ITER = 32
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    localparam int CW = $clog2(NUM_ITER);

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIX, S_DONE} state_t;

    state_t       r_state;
    state_t       w_next;
    logic [2:0]   r_op;
    logic [31:0]  r_a;
    logic [31:0]  r_b;
    logic [31:0]  r_rs1;
    logic         r_sgn1;
    logic         r_sgn2;
    logic [63:0]  r_acc;
    logic [CW-1:0] r_cnt;
    logic [31:0]  r_result;

    logic         w_accept;
    logic         w_s1;
    logic         w_s2;
    logic         w_neg1;
    logic         w_neg2;
    logic         w_div0;
    logic         w_ovf;
    logic         w_special;
    logic [31:0]  w_special_res;
    logic         w_last;
    logic [32:0]  w_add;
    logic [32:0]  w_shrem;
    logic [32:0]  w_sub;
    logic [63:0]  w_prod;
    logic [31:0]  w_quo;
    logic [31:0]  w_rem;
    logic [31:0]  w_fix_res;
    logic         w_wr_result;

    assign w_accept = start && !flush && (r_state == S_IDLE || r_state == S_DONE);

    // rs1 is signed for MUL, MULH, MULHSU, DIV, REM; rs2 for MUL, MULH, DIV, REM
    assign w_s1   = (op != 3'd3) && (op != 3'd5) && (op != 3'd7);
    assign w_s2   = w_s1 && (op != 3'd2);
    assign w_neg1 = w_s1 && rs1_data[31];
    assign w_neg2 = w_s2 && rs2_data[31];

    assign w_div0 = r_op[2] && (r_b == 32'd0);
    assign w_ovf  = (r_op == 3'd4 || r_op == 3'd6) && (r_rs1 == 32'h8000_0000)
                    && r_sgn2 && (r_b == 32'd1);
    assign w_special = w_div0 || w_ovf;
    assign w_special_res = w_div0 ? (r_op[1] ? r_rs1 : 32'hFFFF_FFFF)
                                  : (r_op[1] ? 32'd0 : 32'h8000_0000);

    assign w_last  = (r_cnt == CW'(NUM_ITER - 1));
    assign w_add   = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_a} : 33'd0);
    assign w_shrem = r_acc[63:31];
    assign w_sub   = w_shrem - {1'b0, r_b};

    assign w_prod    = (r_sgn1 ^ r_sgn2) ? (64'd0 - r_acc) : r_acc;
    assign w_quo     = (r_sgn1 ^ r_sgn2) ? (32'd0 - r_acc[31:0]) : r_acc[31:0];
    assign w_rem     = r_sgn1 ? (32'd0 - r_acc[63:32]) : r_acc[63:32];
    assign w_fix_res = r_op[2] ? (r_op[1] ? w_rem : w_quo)
                               : ((r_op == 3'd0) ? w_prod[31:0] : w_prod[63:32]);

    assign w_wr_result = !flush && ((r_state == S_PREP && w_special) || r_state == S_FIX);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (flush) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (start) w_next = S_PREP;
                S_PREP:  w_next = w_special ? S_DONE : S_ITER;
                S_ITER:  if (w_last) w_next = S_FIX;
                S_FIX:   w_next = S_DONE;
                S_DONE:  w_next = start ? S_PREP : S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (r_state == S_PREP) || (r_state == S_ITER) || (r_state == S_FIX);
        done = (r_state == S_DONE);
    end

    // The low accumulator half starts as the multiplier (mul) or dividend (div)
    // so both cores consume one bit from it per iteration.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_op     <= 3'd0;
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_rs1    <= 32'd0;
            r_sgn1   <= 1'b0;
            r_sgn2   <= 1'b0;
            r_acc    <= 64'd0;
            r_cnt    <= '0;
            r_result <= 32'd0;
        end else begin
            if (w_accept) begin
                r_op   <= op;
                r_a    <= w_neg1 ? (32'd0 - rs1_data) : rs1_data;
                r_b    <= w_neg2 ? (32'd0 - rs2_data) : rs2_data;
                r_rs1  <= rs1_data;
                r_sgn1 <= w_neg1;
                r_sgn2 <= w_neg2;
            end
            if (r_state == S_PREP) begin
                r_acc <= r_op[2] ? {32'd0, r_a} : {32'd0, r_b};
                r_cnt <= '0;
            end else if (r_state == S_ITER) begin
                r_cnt <= r_cnt + 1'b1;
                if (!r_op[2]) begin
                    r_acc <= {w_add, r_acc[31:1]};
                end else if (!w_sub[32]) begin
                    r_acc <= {w_sub[31:0], r_acc[30:0], 1'b1};
                end else begin
                    r_acc <= {w_shrem[31:0], r_acc[30:0], 1'b0};
                end
            end
            if (w_wr_result) begin
                r_result <= (r_state == S_FIX) ? w_fix_res : w_special_res;
            end
        end
    end

    assign result = r_result;

endmodule

// File: tb/tb_rv32m_iterative_unit.sv
// Directed bench for rv32m_iterative_unit: an arithmetic reference model plus a
// per-cycle compare process checking done timing and result stability.
module tb_rv32m_iterative_unit;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    bit          cmpEn = 0;
    logic [31:0] expHeld = 32'd0;

    typedef struct {
        int          when;
        logic [31:0] res;
    } exp_t;
    exp_t q[$];

    typedef struct {
        logic [2:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
    } vec_t;
    vec_t vecs[$];

    rv32m_iterative_unit #(.NUM_ITER(32)) dut (
        .CLK(CLK),
        .nRST(nRST),
        .start(start),
        .op(op),
        .rs1_data(rs1_data),
        .rs2_data(rs2_data),
        .flush(flush),
        .busy(busy),
        .done(done),
        .result(result)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Reference semantics straight from the RV32M definitions
    function automatic logic [31:0] modelResult(input logic [2:0] o, input logic [31:0] a,
                                                 input logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        int ia, ib;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        ia = a;
        ib = b;
        p  = 64'd0;
        case (o)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            default: begin
                if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
                if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    return o[1] ? 32'd0 : 32'h8000_0000;
                case (o)
                    3'd4:    return ia / ib;
                    3'd5:    return a / b;
                    3'd6:    return ia % ib;
                    default: return a % b;
                endcase
            end
        endcase
    endfunction

    function automatic int modelLatency(input logic [2:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
        if (o[2] && b == 32'd0) return 1;
        if ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Called at a negedge with the unit in IDLE or DONE; returns at the negedge after accept
    task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        op       = o;
        rs1_data = a;
        rs2_data = b;
        start    = 1'b1;
        e.when   = cyc + 1 + modelLatency(o, a, b);
        e.res    = modelResult(o, a, b);
        q.push_back(e);
        @(posedge CLK);
        #1;
        start    = 1'b0;
        op       = 3'($urandom);
        rs1_data = $urandom;
        rs2_data = $urandom;
        @(negedge CLK);
    endtask

    task automatic waitDone();
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL done_timeout: got no done, expected done at cycle %0d", q[0].when);
            q.delete();
        end
        @(negedge CLK);
    endtask

    always @(negedge CLK) begin
        if (cmpEn) begin
            if (q.size() != 0 && cyc == q[0].when) begin
                checkOutput("done_pulse", done, 1'b1);
                checkOutput("result", result, q[0].res);
                expHeld = q[0].res;
                void'(q.pop_front());
            end else begin
                checkOutput("done_quiet", done, 1'b0);
                checkOutput("result_hold", result, expHeld);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before 2ms");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs.push_back('{3'd0, 32'd7,          32'd6,          32'd42});
        vecs.push_back('{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000});
        vecs.push_back('{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF});
        vecs.push_back('{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE});
        vecs.push_back('{3'd4, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD});
        vecs.push_back('{3'd6, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF});
        vecs.push_back('{3'd5, 32'd100,        32'd7,          32'd14});
        vecs.push_back('{3'd7, 32'd100,        32'd7,          32'd2});
        vecs.push_back('{3'd5, 32'd5,          32'd0,          32'hFFFF_FFFF});
        vecs.push_back('{3'd6, 32'd5,          32'd0,          32'd5});
        vecs.push_back('{3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000});
        vecs.push_back('{3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0});
        vecs.push_back('{3'd0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000});
        vecs.push_back('{3'd1, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000});
        vecs.push_back('{3'd4, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD});
        vecs.push_back('{3'd6, 32'd7,          32'hFFFF_FFFE,  32'd1});
        vecs.push_back('{3'd5, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF});
        vecs.push_back('{3'd4, 32'd0,          32'd0,          32'hFFFF_FFFF});

        nRST = 1'b0; start = 1'b0; flush = 1'b0;
        op = 3'd0; rs1_data = 32'd0; rs2_data = 32'd0;
        repeat (3) @(negedge CLK);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_done", done, 1'b0);
        checkOutput("reset_result", result, 32'd0);
        nRST = 1'b1;
        @(negedge CLK);
        cmpEn = 1;

        // reset in the middle of a multiply discards it
        applyStimulus(3'd0, 32'd7, 32'd6);
        repeat (9) @(negedge CLK);
        #1;
        nRST = 1'b0;
        q.delete();
        expHeld = 32'd0;
        #1;
        checkOutput("midreset_busy", busy, 1'b0);
        checkOutput("midreset_done", done, 1'b0);
        checkOutput("midreset_result", result, 32'd0);
        @(negedge CLK);
        nRST = 1'b1;
        repeat (40) @(negedge CLK);

        foreach (vecs[i]) begin
            checkOutput("model_pin", modelResult(vecs[i].o, vecs[i].a, vecs[i].b), vecs[i].r);
            applyStimulus(vecs[i].o, vecs[i].a, vecs[i].b);
            waitDone();
        end

        // start held in the DONE cycle starts the next op back-to-back
        applyStimulus(3'd0, 32'd7, 32'd6);
        repeat (34) @(negedge CLK);
        applyStimulus(3'd4, 32'hFFFF_FFF9, 32'd2);
        checkOutput("b2b_busy", busy, 1'b1);
        waitDone();

        // start re-pulsed during ITER must be ignored
        applyStimulus(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (10) @(negedge CLK);
        op = 3'd0; rs1_data = 32'd3; rs2_data = 32'd3; start = 1'b1;
        @(posedge CLK);
        #1 start = 1'b0;
        @(negedge CLK);
        checkOutput("repulse_busy", busy, 1'b1);
        waitDone();

        // flush mid-divide: no done, result held
        applyStimulus(3'd5, 32'd100, 32'd7);
        repeat (5) @(negedge CLK);
        flush = 1'b1;
        q.delete();
        @(posedge CLK);
        #1 flush = 1'b0;
        @(negedge CLK);
        checkOutput("flush_busy", busy, 1'b0);
        repeat (40) @(negedge CLK);

        // flush wins over a simultaneous start
        op = 3'd0; rs1_data = 32'd7; rs2_data = 32'd6;
        flush = 1'b1; start = 1'b1;
        @(posedge CLK);
        #1;
        flush = 1'b0; start = 1'b0;
        @(negedge CLK);
        checkOutput("flushstart_busy", busy, 1'b0);
        repeat (40) @(negedge CLK);

        cmpEn = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
